ireg_bypass: RTL and testbench

// - Parametrised successor of the integer register file: NRP synchronous read ports, one

---
 rtl/ireg_bypass_if.sv | 27 ++
 rtl/ireg_bypass.sv | 128 ++++++++++++
 tb/tb_ireg_bypass.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ireg_bypass_if.sv
// Register-file access bundle: read addresses and write pipeline in, read data out.
// The core (decode/execute/writeback) is the master; the register file is the slave.
interface ireg_bypass_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   parameter int unsigned NRP  = 2
);
   localparam int unsigned AW = $clog2(NREG);

   logic [NRP*AW-1:0]   rs_addr;
   logic                wr_v;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                wr_kill;
   logic [NRP*XLEN-1:0] rs_data;
   logic [NRP-1:0]      par_err;

   modport master (
      output rs_addr, wr_v, wr_addr, wr_data, wr_kill,
      input  rs_data, par_err
   );

   modport slave (
      input  rs_addr, wr_v, wr_addr, wr_data, wr_kill,
      output rs_data, par_err
   );
endinterface

// File: rtl/ireg_bypass.sv
// Integer register file with NRP synchronous read ports, one pipelined write port
// (X -> M -> W) and full X/M/W forwarding. Optional hardwired-zero entry 0.
// Define IREG_PARITY_EN to store an even-parity bit per entry and flag array-sourced
// read errors on par_err; otherwise par_err is tied to 0.
module ireg_bypass #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREG     = 32,
   parameter int unsigned NRP      = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input logic          clk,
   input logic          rst_n,
   ireg_bypass_if.slave bus
);
   localparam int unsigned AW = $clog2(NREG);
`ifdef IREG_PARITY_EN
   localparam int unsigned MW = XLEN + 1;
`else
   localparam int unsigned MW = XLEN;
`endif

   logic [MW-1:0]       mem_q [NREG];

   // M and W stages of the write pipeline
   logic                m_v_q;
   logic [AW-1:0]       m_addr_q;
   logic [XLEN-1:0]     m_data_q;
   logic                w_v_q;
   logic [XLEN-1:0]     w_data_q;

   // Per-port registered read address and source selects
   logic                rd_en_q;
   logic [NRP*AW-1:0]   ra_q;
   logic [NRP-1:0]      x_hit_d, x_hit_q;
   logic [NRP-1:0]      m_hit_d, m_hit_q;
   logic [NRP-1:0]      zero_d, zero_q;

   logic                wr_ok;
   logic                commit;
   logic [MW-1:0]       rd_arr;
   logic [NRP*XLEN-1:0] rd_data;
   logic [NRP-1:0]      rd_perr;

   // Writes to the hardwired zero entry are dropped before entering M
   assign wr_ok  = bus.wr_v && !((ZERO_REG != 0) && (bus.wr_addr == '0));
   assign commit = m_v_q && !bus.wr_kill;

   // Forwarding selects per read port, X beats M so the younger write wins
   always_comb begin
      x_hit_d = '0;
      m_hit_d = '0;
      zero_d  = '0;
      for (int p = 0; p < NRP; p++) begin
         x_hit_d[p] = wr_ok && (bus.wr_addr == bus.rs_addr[p*AW +: AW]);
         m_hit_d[p] = commit && (m_addr_q == bus.rs_addr[p*AW +: AW]);
         zero_d[p]  = (ZERO_REG != 0) && (bus.rs_addr[p*AW +: AW] == '0);
      end
   end

   // Control state: valids and read selects, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_v_q   <= 1'b0;
         w_v_q   <= 1'b0;
         rd_en_q <= 1'b0;
         ra_q    <= '0;
         x_hit_q <= '0;
         m_hit_q <= '0;
         zero_q  <= '0;
      end else begin
         m_v_q   <= wr_ok;
         w_v_q   <= commit;
         rd_en_q <= 1'b1;
         ra_q    <= bus.rs_addr;
         x_hit_q <= x_hit_d;
         m_hit_q <= m_hit_d;
         zero_q  <= zero_d;
      end
   end

   // Pipeline payload registers, qualified by the valids above
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         m_addr_q <= bus.wr_addr;
         m_data_q <= bus.wr_data;
      end
      if (commit) begin
         w_data_q <= m_data_q;
      end
   end

   // Array write at the commit edge; array contents are not reset
   always_ff @(posedge clk) begin
      if (commit) begin
`ifdef IREG_PARITY_EN
         mem_q[m_addr_q] <= {^m_data_q, m_data_q};
`else
         mem_q[m_addr_q] <= m_data_q;
`endif
      end
   end

   // Read data mux; a kill in this cycle cancels the X forward and falls back to older data
   always_comb begin
      rd_data = '0;
      rd_perr = '0;
      rd_arr  = '0;
      for (int p = 0; p < NRP; p++) begin
         rd_arr = mem_q[ra_q[p*AW +: AW]];
         if (!rd_en_q || zero_q[p]) begin
            rd_data[p*XLEN +: XLEN] = '0;
         end else if (x_hit_q[p] && !bus.wr_kill) begin
            rd_data[p*XLEN +: XLEN] = m_data_q;
         end else if (m_hit_q[p] && w_v_q) begin
            rd_data[p*XLEN +: XLEN] = w_data_q;
         end else begin
            rd_data[p*XLEN +: XLEN] = rd_arr[XLEN-1:0];
`ifdef IREG_PARITY_EN
            rd_perr[p] = ^rd_arr;
`endif
         end
      end
   end

   assign bus.rs_data = rd_data;
   assign bus.par_err = rd_perr;

endmodule

// File: tb/tb_ireg_bypass.sv
// Bench for ireg_bypass: two instances (ZERO_REG=1 and ZERO_REG=0) share one stimulus
// stream; expected read data is queued per read and checked one cycle later.
module tb_ireg_bypass;
   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRP  = 2;
   localparam int unsigned AW   = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NRP*AW-1:0] rs_addr;
   logic              wr_v;
   logic [AW-1:0]     wr_addr;
   logic [XLEN-1:0]   wr_data;
   logic              wr_kill;

   ireg_bypass_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) bus1 ();
   ireg_bypass_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) bus0 ();

   assign bus1.rs_addr = rs_addr;
   assign bus1.wr_v    = wr_v;
   assign bus1.wr_addr = wr_addr;
   assign bus1.wr_data = wr_data;
   assign bus1.wr_kill = wr_kill;
   assign bus0.rs_addr = rs_addr;
   assign bus0.wr_v    = wr_v;
   assign bus0.wr_addr = wr_addr;
   assign bus0.wr_data = wr_data;
   assign bus0.wr_kill = wr_kill;

   ireg_bypass #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .ZERO_REG(1)) dut_z1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   ireg_bypass #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .ZERO_REG(0)) dut_z0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   typedef struct {
      int              due;
      int              port;
      logic [XLEN-1:0] exp1;
      logic [XLEN-1:0] exp0;
      logic            perr;
      string           name;
   } sb_t;

   sb_t sb_q[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc_n = 0;

   task automatic idle_inputs();
      wr_v    = 1'b0;
      wr_kill = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      rs_addr = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wr_v    = 1'b1;
      wr_addr = a;
      wr_data = d;
   endtask

   // Drive a read this cycle and queue its expected result for the next cycle
   task automatic rd(input int port, input logic [AW-1:0] a, input logic [XLEN-1:0] e1,
                     input logic [XLEN-1:0] e0, input logic pe, input string nm);
      sb_t e;
      rs_addr[port*AW +: AW] = a;
      e.due  = cyc_n + 1;
      e.port = port;
      e.exp1 = e1;
      e.exp0 = e0;
      e.perr = pe;
      e.name = nm;
      sb_q.push_back(e);
   endtask

   // Check reads due now (before the sampling edge), then advance one cycle
   task automatic step();
      sb_t             e;
      logic [XLEN-1:0] got1, got0;
      logic            gotp;
      @(negedge clk);
      while (sb_q.size() != 0 && sb_q[0].due <= cyc_n) begin
         e    = sb_q.pop_front();
         got1 = bus1.rs_data[e.port*XLEN +: XLEN];
         got0 = bus0.rs_data[e.port*XLEN +: XLEN];
         gotp = bus1.par_err[e.port];
         total++;
         if (e.due != cyc_n || got1 !== e.exp1) begin
            bad++;
            $display("FAIL %s z1 port%0d: got %h want %h (cycle %0d due %0d)", e.name,
                     e.port, got1, e.exp1, cyc_n, e.due);
         end
         total++;
         if (got0 !== e.exp0) begin
            bad++;
            $display("FAIL %s z0 port%0d: got %h want %h", e.name, e.port, got0, e.exp0);
         end
         total++;
         if (gotp !== e.perr) begin
            bad++;
            $display("FAIL %s par_err port%0d: got %b want %b", e.name, e.port, gotp, e.perr);
         end
      end
      @(posedge clk);
      #1;
      cyc_n++;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus1.rs_data !== '0) begin
         bad++;
         $display("FAIL reset_rs_data z1: got %h want 0", bus1.rs_data);
      end
      total++;
      if (bus0.rs_data !== '0) begin
         bad++;
         $display("FAIL reset_rs_data z0: got %h want 0", bus0.rs_data);
      end
      total++;
      if (bus1.par_err !== '0) begin
         bad++;
         $display("FAIL reset_par_err z1: got %b want 0", bus1.par_err);
      end
      total++;
      if (bus0.par_err !== '0) begin
         bad++;
         $display("FAIL reset_par_err z0: got %b want 0", bus0.par_err);
      end
      rst_n = 1'b1;
   endtask

   task automatic preload();
      wr(5'd5, 32'h0000_AAAA);  step();
      wr(5'd9, 32'h0000_0011);  step();
      wr(5'd12, 32'h0F0F_0F0F); step();
      step();
      step();
   endtask

   // Reset asserted while x5=0x1234 sits in M: the write must be discarded
   task automatic test_reset_mid_write();
      wr(5'd5, 32'h0000_1234);
      rs_addr[1*AW +: AW] = 5'd5;
      step();
      rst_n = 1'b0;
      #1;
      total++;
      if (bus1.rs_data !== '0) begin
         bad++;
         $display("FAIL midreset_rs_data z1: got %h want 0", bus1.rs_data);
      end
      total++;
      if (bus0.rs_data !== '0) begin
         bad++;
         $display("FAIL midreset_rs_data z0: got %h want 0", bus0.rs_data);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      rd(0, 5'd5, 32'h0000_AAAA, 32'h0000_AAAA, 1'b0, "midreset_x5");
      step();
      step();
   endtask

   task automatic test_x_bypass();
      wr(5'd3, 32'hDEAD_BEEF);
      rd(0, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "byp_x");
      rd(1, 5'd5, 32'h0000_AAAA, 32'h0000_AAAA, 1'b0, "byp_other");
      step();
      rd(1, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "byp_w");
      step();
      step();
      rd(0, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "byp_arr");
      step();
      step();
   endtask

   task automatic test_back_to_back();
      wr(5'd7, 32'd1);
      step();
      wr(5'd7, 32'd2);
      rd(0, 5'd7, 32'd2, 32'd2, 1'b0, "b2b_x");
      step();
      rd(1, 5'd7, 32'd2, 32'd2, 1'b0, "b2b_m");
      step();
      step();
      rd(0, 5'd7, 32'd2, 32'd2, 1'b0, "b2b_arr");
      step();
      step();
   endtask

   task automatic test_kill();
      wr(5'd9, 32'h0000_0055);
      rd(0, 5'd9, 32'h0000_0011, 32'h0000_0011, 1'b0, "kill_t");
      step();
      wr_kill = 1'b1;
      rd(1, 5'd9, 32'h0000_0011, 32'h0000_0011, 1'b0, "kill_t1");
      step();
      step();
      step();
      step();
      rd(0, 5'd9, 32'h0000_0011, 32'h0000_0011, 1'b0, "kill_t5");
      step();
      step();
   endtask

   task automatic test_zero_reg();
      wr(5'd0, 32'h0000_FFFF);
      rd(0, 5'd0, 32'h0, 32'h0000_FFFF, 1'b0, "zero_t_p0");
      rd(1, 5'd0, 32'h0, 32'h0000_FFFF, 1'b0, "zero_t_p1");
      step();
      step();
      step();
      rd(0, 5'd0, 32'h0, 32'h0000_FFFF, 1'b0, "zero_t3_p0");
      rd(1, 5'd0, 32'h0, 32'h0000_FFFF, 1'b0, "zero_t3_p1");
      step();
      step();
   endtask

   task automatic test_same_addr();
      wr(5'd20, 32'hCAFE_F00D);
      rd(0, 5'd20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "same_x_p0");
      rd(1, 5'd20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "same_x_p1");
      step();
      rd(0, 5'd20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "same_w_p0");
      rd(1, 5'd20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "same_w_p1");
      step();
      step();
      rd(0, 5'd20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "same_arr_p0");
      rd(1, 5'd20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "same_arr_p1");
      step();
      rd(0, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "mix_p0");
      rd(1, 5'd7, 32'd2, 32'd2, 1'b0, "mix_p1");
      step();
      step();
   endtask

`ifdef IREG_PARITY_EN
   task automatic test_parity();
      dut_z1.mem_q[12][4] = ~dut_z1.mem_q[12][4];
      rd(0, 5'd12, 32'h0F0F_0F1F, 32'h0F0F_0F0F, 1'b1, "par_arr");
      step();
      step();
      wr(5'd12, 32'h0F0F_0F0F);
      rd(0, 5'd12, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, "par_fwd");
      step();
      step();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      @(posedge clk);
      #1;
      preload();
      test_reset_mid_write();
      test_x_bypass();
      test_back_to_back();
      test_kill();
      test_zero_reg();
      test_same_addr();
`ifdef IREG_PARITY_EN
      test_parity();
`endif
      step();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
